// File: rtl/vliw_pkg.sv
// Shared opcode encodings and slot field layout for the VLIW execution unit.
package vliw_pkg;

    localparam int OP_ADD = 'h00;
    localparam int OP_SUB = 'h01;
    localparam int OP_AND = 'h02;
    localparam int OP_OR  = 'h03;
    localparam int OP_XOR = 'h04;
    localparam int OP_NOT = 'h05;
    localparam int OP_SHL = 'h06;
    localparam int OP_SHR = 'h07;
    localparam int OP_LDI = 'h08;
    localparam int OP_NOP = 'hFF;

    // Field index counted from the slot LSB: rs2, rs1, rd, opc.
    localparam int FLD_RS2 = 0;
    localparam int FLD_RS1 = 1;
    localparam int FLD_RD  = 2;
    localparam int FLD_OPC = 3;

    function automatic int slot_w(input int opc_w, input int ra_w);
        return opc_w + 3 * ra_w;
    endfunction

    function automatic int fld_lsb(input int idx, input int ra_w);
        return idx * ra_w;
    endfunction

endpackage

// File: rtl/vliw_alu_slot.sv
// Single-slot combinational ALU: result, regfile write enable, illegal flag.
module vliw_alu_slot
    import vliw_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 8,
    parameter int IMM_W  = 8
) (
    input  logic [OPC_W-1:0]  i_opc,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [IMM_W-1:0]  i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_we,
    output logic              o_err
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [OPC_W-1:0] C_ADD = OPC_W'(OP_ADD);
    localparam logic [OPC_W-1:0] C_SUB = OPC_W'(OP_SUB);
    localparam logic [OPC_W-1:0] C_AND = OPC_W'(OP_AND);
    localparam logic [OPC_W-1:0] C_OR  = OPC_W'(OP_OR);
    localparam logic [OPC_W-1:0] C_XOR = OPC_W'(OP_XOR);
    localparam logic [OPC_W-1:0] C_NOT = OPC_W'(OP_NOT);
    localparam logic [OPC_W-1:0] C_SHL = OPC_W'(OP_SHL);
    localparam logic [OPC_W-1:0] C_SHR = OPC_W'(OP_SHR);
    localparam logic [OPC_W-1:0] C_LDI = OPC_W'(OP_LDI);
    localparam logic [OPC_W-1:0] C_NOP = OPC_W'(OP_NOP);

    logic [SH_W-1:0] w_sh;

    assign w_sh = i_b[SH_W-1:0];

    always_comb begin
        o_result = '0;
        o_we     = 1'b1;
        o_err    = 1'b0;
        case (i_opc)
            C_ADD: o_result = i_a + i_b;
            C_SUB: o_result = i_a - i_b;
            C_AND: o_result = i_a & i_b;
            C_OR:  o_result = i_a | i_b;
            C_XOR: o_result = i_a ^ i_b;
            C_NOT: o_result = ~i_a;
            C_SHL: o_result = i_a << w_sh;
            C_SHR: o_result = i_a >> w_sh;
            C_LDI: o_result = DATA_W'(i_imm);
            C_NOP: o_we = 1'b0;
            default: begin
                o_we  = 1'b0;
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vliw_exec_unit.sv
// N-slot VLIW execution unit: regfile, RD/EX pipeline, forwarding, handshakes.
module vliw_exec_unit
    import vliw_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_SLOTS  = 2,
    parameter int REG_ADDR_W = 4,
    parameter int OPC_W      = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [NUM_SLOTS*(OPC_W+3*REG_ADDR_W)-1:0]   in_bundle,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [NUM_SLOTS*DATA_W-1:0]                 out_result,
    output logic [NUM_SLOTS-1:0]                        out_err,
    input  logic [REG_ADDR_W-1:0]                       dbg_addr,
    output logic [DATA_W-1:0]                           dbg_data
);
    localparam int SLOT_W   = slot_w(OPC_W, REG_ADDR_W);
    localparam int IMM_W    = 2 * REG_ADDR_W;
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0]          r_rf     [NUM_REGS];
    logic                       r_s1_valid;
    logic [OPC_W-1:0]           r_s1_opc [NUM_SLOTS];
    logic [REG_ADDR_W-1:0]      r_s1_rd  [NUM_SLOTS];
    logic [DATA_W-1:0]          r_s1_a   [NUM_SLOTS];
    logic [DATA_W-1:0]          r_s1_b   [NUM_SLOTS];
    logic [IMM_W-1:0]           r_s1_imm [NUM_SLOTS];
    logic                       r_out_valid;
    logic [NUM_SLOTS*DATA_W-1:0] r_out_result;
    logic [NUM_SLOTS-1:0]       r_out_err;

    logic [OPC_W-1:0]           w_in_opc [NUM_SLOTS];
    logic [REG_ADDR_W-1:0]      w_in_rd  [NUM_SLOTS];
    logic [REG_ADDR_W-1:0]      w_in_rs1 [NUM_SLOTS];
    logic [REG_ADDR_W-1:0]      w_in_rs2 [NUM_SLOTS];
    logic [DATA_W-1:0]          w_op_a   [NUM_SLOTS];
    logic [DATA_W-1:0]          w_op_b   [NUM_SLOTS];
    logic [DATA_W-1:0]          w_res    [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]       w_we;
    logic [NUM_SLOTS-1:0]       w_err;
    logic [NUM_SLOTS*DATA_W-1:0] w_res_flat;
    logic                       w_advance;

    assign w_advance  = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_advance;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_err    = r_out_err;
    assign dbg_data   = r_rf[dbg_addr];

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        localparam int BASE = s * SLOT_W;

        assign w_in_rs2[s] = in_bundle[BASE + fld_lsb(FLD_RS2, REG_ADDR_W) +: REG_ADDR_W];
        assign w_in_rs1[s] = in_bundle[BASE + fld_lsb(FLD_RS1, REG_ADDR_W) +: REG_ADDR_W];
        assign w_in_rd[s]  = in_bundle[BASE + fld_lsb(FLD_RD, REG_ADDR_W) +: REG_ADDR_W];
        assign w_in_opc[s] = in_bundle[BASE + fld_lsb(FLD_OPC, REG_ADDR_W) +: OPC_W];

        vliw_alu_slot #(
            .DATA_W (DATA_W),
            .OPC_W  (OPC_W),
            .IMM_W  (IMM_W)
        ) u_alu (
            .i_opc    (r_s1_opc[s]),
            .i_a      (r_s1_a[s]),
            .i_b      (r_s1_b[s]),
            .i_imm    (r_s1_imm[s]),
            .o_result (w_res[s]),
            .o_we     (w_we[s]),
            .o_err    (w_err[s])
        );

        assign w_res_flat[s*DATA_W +: DATA_W] = w_res[s];
    end

    // Ascending scan lets the highest writing slot of the RD bundle win.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            w_op_a[s] = r_rf[w_in_rs1[s]];
            w_op_b[s] = r_rf[w_in_rs2[s]];
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (r_s1_valid && w_we[k] && r_s1_rd[k] == w_in_rs1[s])
                    w_op_a[s] = w_res[k];
                if (r_s1_valid && w_we[k] && r_s1_rd[k] == w_in_rs2[s])
                    w_op_b[s] = w_res[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_rf[i] <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                r_s1_opc[s] <= '0;
                r_s1_rd[s]  <= '0;
                r_s1_a[s]   <= '0;
                r_s1_b[s]   <= '0;
                r_s1_imm[s] <= '0;
            end
            r_s1_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_err    <= '0;
        end else begin
            if (w_advance) begin
                if (r_s1_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_result <= w_res_flat;
                    r_out_err    <= w_err;
                    for (int s = 0; s < NUM_SLOTS; s++)
                        if (w_we[s])
                            r_rf[r_s1_rd[s]] <= w_res[s];
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        r_s1_opc[s] <= w_in_opc[s];
                        r_s1_rd[s]  <= w_in_rd[s];
                        r_s1_a[s]   <= w_op_a[s];
                        r_s1_b[s]   <= w_op_b[s];
                        r_s1_imm[s] <= {w_in_rs1[s], w_in_rs2[s]};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vliw_exec_unit.sv
// Directed bench for vliw_exec_unit with DATA_W=8, NUM_SLOTS=2.
module tb_vliw_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_bundle;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [1:0]  out_err;
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int vectors;
    int miscompares;

    vliw_exec_unit #(
        .DATA_W     (8),
        .NUM_SLOTS  (2),
        .REG_ADDR_W (4),
        .OPC_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bundle  (in_bundle),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] sl(input logic [7:0] opc, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2);
        return {opc, rd, rs1, rs2};
    endfunction

    function automatic logic [19:0] ldi(input logic [3:0] rd, input logic [7:0] v);
        return sl(8'h08, rd, v[7:4], v[3:0]);
    endfunction

    function automatic logic [19:0] nop();
        return sl(8'hFF, 4'h0, 4'h0, 4'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [39:0] b);
        in_bundle = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic dbg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic run(input string tag, input logic [39:0] b,
                       input logic [15:0] eres, input logic [1:0] eerr);
        send(b);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_res"}, out_result, eres);
        chk({tag, "_err"}, out_err, eerr);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_bundle   = '0;
        out_ready   = 1'b1;
        dbg_addr    = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Reset state
        for (int i = 0; i < 16; i++)
            dbg("rst_reg", 4'(i), 8'h00);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_result", out_result, 16'h0000);

        // LDI pair with two-cycle latency
        run("ldi", {ldi(4'd2, 8'h05), ldi(4'd1, 8'h3C)}, 16'h053C, 2'b00);
        dbg("ldi_r1", 4'd1, 8'h3C);
        dbg("ldi_r2", 4'd2, 8'h05);
        tick();
        chk("idle_valid", out_valid, 0);

        // Back-to-back with forwarding
        send({nop(), ldi(4'd1, 8'h10)});
        send({sl(8'h01, 4'd4, 4'd1, 4'd1), sl(8'h00, 4'd3, 4'd1, 4'd1)});
        chk("fwdA_res", out_result, 16'h0010);
        tick();
        chk("fwdB_valid", out_valid, 1);
        chk("fwdB_res", out_result, 16'h0020);
        dbg("fwd_r3", 4'd3, 8'h20);
        dbg("fwd_r4", 4'd4, 8'h00);

        // WAW and illegal opcode
        run("waw", {ldi(4'd5, 8'h22), ldi(4'd5, 8'h11)}, 16'h2211, 2'b00);
        dbg("waw_r5", 4'd5, 8'h22);
        run("ill", {nop(), sl(8'h40, 4'd1, 4'd0, 4'd0)}, 16'h0000, 2'b01);
        dbg("ill_r1", 4'd1, 8'h10);

        // Remaining ALU ops
        run("or_xor", {sl(8'h04, 4'd8, 4'd2, 4'd5), sl(8'h03, 4'd7, 4'd1, 4'd2)},
            16'h2715, 2'b00);
        run("shl_shr", {sl(8'h07, 4'd10, 4'd5, 4'd2), sl(8'h06, 4'd9, 4'd2, 4'd2)},
            16'h01A0, 2'b00);
        run("not_and", {sl(8'h02, 4'd12, 4'd3, 4'd5), sl(8'h05, 4'd11, 4'd1, 4'd0)},
            16'h20EF, 2'b00);
        run("shmask_sub", {sl(8'h01, 4'd14, 4'd2, 4'd3), sl(8'h06, 4'd13, 4'd2, 4'd1)},
            16'hE505, 2'b00);
        dbg("sub_r14", 4'd14, 8'hE5);

        // Backpressure with two bundles issued
        tick();
        out_ready = 1'b0;
        send({ldi(4'd7, 8'h01), ldi(4'd6, 8'h66)});
        send({nop(), sl(8'h00, 4'd8, 4'd6, 4'd6)});
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_res", out_result, 16'h0166);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_res", out_result, 16'h0166);
            chk("bp_hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_valid", out_valid, 1);
        chk("bp_rel_res", out_result, 16'h00CC);
        tick();
        chk("bp_drain_valid", out_valid, 0);
        dbg("bp_r8", 4'd8, 8'hCC);

        // Reset with two bundles in flight
        out_ready = 1'b0;
        send({nop(), ldi(4'd9, 8'h99)});
        send({ldi(4'd0, 8'hBB), ldi(4'd15, 8'hAA)});
        chk("fl_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        chk("rst_fl_valid", out_valid, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_fl_after", out_valid, 0);
        dbg("rst_fl_r15", 4'd15, 8'h00);
        dbg("rst_fl_r0", 4'd0, 8'h00);
        dbg("rst_fl_r9", 4'd9, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
